// File: rtl/dly_tap_ctrl_pkg.sv
// Shared definitions for the tap-walking controller: FSM states, tap width and step timing.
package dly_tap_ctrl_pkg;

  localparam int TAP_W = 6;
  localparam logic [TAP_W-1:0] TAP_MAX = 6'd63;
  localparam int STEP_CYCLES = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_LWAIT = 3'd2,
    S_STEP  = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  // One tap step in the requested direction, held at the rails.
  function automatic logic [TAP_W-1:0] tap_step(input logic [TAP_W-1:0] tap, input logic up);
    if (up) return (tap == TAP_MAX) ? tap : tap + 1'b1;
    return (tap == '0) ? tap : tap - 1'b1;
  endfunction

endpackage

// File: rtl/dly_tap_ctrl.sv
// Walks an input-delay primitive to an absolute tap with spaced single-step adjust pulses.
// DLY_TAP_CTRL_FEEDBACK_EN selects closed-loop tap feedback; undefined gives open-loop tracking.
module dly_tap_ctrl
  import dly_tap_ctrl_pkg::*;
#(
  parameter int DELAY   = 0,
  parameter int TIMEOUT = 8
) (
  input  logic             CLK_IN,
  input  logic             RST,
  input  logic             LOAD_REQ,
  input  logic [TAP_W-1:0] TARGET_TAP,
  input  logic             TARGET_VALID,
  output logic             TARGET_READY,
  input  logic [TAP_W-1:0] DLY_TAP_VALUE,
  output logic             DLY_LOAD,
  output logic             DLY_ADJ,
  output logic             DLY_INCDEC,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERROR
);

  localparam logic [TAP_W-1:0] LOAD_TAP  = TAP_W'(DELAY);
  localparam logic [7:0]       TMO       = 8'(TIMEOUT);
  localparam logic [7:0]       WAIT_LAST = 8'(STEP_CYCLES - 2);

  state_t           state_reg, state_next;
  logic [TAP_W-1:0] tgt_reg, tgt_next;
  logic [7:0]       cnt_reg, cnt_next, cnt_inc;
  logic             ready_reg, ready_next;
  logic             load_reg, load_next;
  logic             adj_reg, adj_next;
  logic             incdec_reg, incdec_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
`ifdef DLY_TAP_CTRL_FEEDBACK_EN
  logic [TAP_W-1:0] prev_reg, prev_next;
  logic             error_reg, error_next;
  logic             progressing;
`else
  logic [TAP_W-1:0] trk_reg, trk_next;
`endif

  assign cnt_inc = (cnt_reg >= TMO) ? cnt_reg : cnt_reg + 8'd1;

`ifdef DLY_TAP_CTRL_FEEDBACK_EN
  // A legal move is strictly toward the target without passing it.
  assign progressing = incdec_reg ? (DLY_TAP_VALUE > prev_reg && DLY_TAP_VALUE < tgt_reg)
                                  : (DLY_TAP_VALUE < prev_reg && DLY_TAP_VALUE > tgt_reg);
`endif

  always_comb begin
    state_next  = state_reg;
    tgt_next    = tgt_reg;
    cnt_next    = cnt_reg;
    incdec_next = incdec_reg;
    load_next   = 1'b0;
    adj_next    = 1'b0;
    done_next   = 1'b0;
`ifdef DLY_TAP_CTRL_FEEDBACK_EN
    prev_next   = prev_reg;
    error_next  = error_reg;
`else
    trk_next    = trk_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (LOAD_REQ) begin
          state_next = S_LOAD;
          load_next  = 1'b1;
`ifdef DLY_TAP_CTRL_FEEDBACK_EN
          error_next = 1'b0;
`endif
        end else if (TARGET_VALID && ready_reg) begin
          tgt_next = TARGET_TAP;
`ifdef DLY_TAP_CTRL_FEEDBACK_EN
          error_next = 1'b0;
`else
          trk_next = DLY_TAP_VALUE;
`endif
          if (TARGET_TAP == DLY_TAP_VALUE) begin
            state_next = S_DONE;
            done_next  = 1'b1;
          end else begin
            state_next  = S_STEP;
            adj_next    = 1'b1;
            incdec_next = (TARGET_TAP > DLY_TAP_VALUE);
          end
        end
      end
      S_LOAD: begin
        state_next = S_LWAIT;
        cnt_next   = '0;
      end
      S_LWAIT: begin
`ifdef DLY_TAP_CTRL_FEEDBACK_EN
        if (DLY_TAP_VALUE == LOAD_TAP) begin
          state_next = S_DONE;
          done_next  = 1'b1;
        end else if (cnt_inc >= TMO) begin
          state_next = S_ERR;
          error_next = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
`else
        if (cnt_reg == WAIT_LAST) begin
          state_next = S_DONE;
          done_next  = 1'b1;
          trk_next   = LOAD_TAP;
        end else begin
          cnt_next = cnt_inc;
        end
`endif
      end
      S_STEP: begin
        state_next = S_WAIT;
        cnt_next   = '0;
`ifdef DLY_TAP_CTRL_FEEDBACK_EN
        prev_next  = DLY_TAP_VALUE;
`else
        trk_next   = tap_step(trk_reg, incdec_reg);
`endif
      end
      S_WAIT: begin
`ifdef DLY_TAP_CTRL_FEEDBACK_EN
        if (DLY_TAP_VALUE != prev_reg) begin
          if (DLY_TAP_VALUE == tgt_reg) begin
            state_next = S_DONE;
            done_next  = 1'b1;
          end else if (!progressing) begin
            state_next = S_ERR;
            error_next = 1'b1;
          end else begin
            state_next = S_STEP;
            adj_next   = 1'b1;
          end
        end else if (cnt_inc >= TMO) begin
          state_next = S_ERR;
          error_next = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
`else
        if (cnt_reg == WAIT_LAST) begin
          if (trk_reg == tgt_reg) begin
            state_next = S_DONE;
            done_next  = 1'b1;
          end else begin
            state_next = S_STEP;
            adj_next   = 1'b1;
          end
        end else begin
          cnt_next = cnt_inc;
        end
`endif
      end
      S_DONE:  state_next = S_IDLE;
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    // Outputs are registered, so they are derived from the state being entered.
    ready_next = (state_next == S_IDLE) && !LOAD_REQ;
    busy_next  = (state_next != S_IDLE);
  end

  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      state_reg  <= S_IDLE;
      tgt_reg    <= '0;
      cnt_reg    <= '0;
      ready_reg  <= 1'b1;
      load_reg   <= 1'b0;
      adj_reg    <= 1'b0;
      incdec_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
`ifdef DLY_TAP_CTRL_FEEDBACK_EN
      prev_reg   <= '0;
      error_reg  <= 1'b0;
`else
      trk_reg    <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      tgt_reg    <= tgt_next;
      cnt_reg    <= cnt_next;
      ready_reg  <= ready_next;
      load_reg   <= load_next;
      adj_reg    <= adj_next;
      incdec_reg <= incdec_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
`ifdef DLY_TAP_CTRL_FEEDBACK_EN
      prev_reg   <= prev_next;
      error_reg  <= error_next;
`else
      trk_reg    <= trk_next;
`endif
    end
  end

  assign TARGET_READY = ready_reg;
  assign DLY_LOAD     = load_reg;
  assign DLY_ADJ      = adj_reg;
  assign DLY_INCDEC   = incdec_reg;
  assign BUSY         = busy_reg;
  assign DONE         = done_reg;
`ifdef DLY_TAP_CTRL_FEEDBACK_EN
  assign ERROR        = error_reg;
`else
  assign ERROR        = 1'b0;
`endif

endmodule
